fpu_dispatch: RTL and testbench

- Sits directly downstream of the float decode FSM. Accepts its one-cycle fpu_go pulse and returns a one-cycle fpu_valid pulse with the result.
- Drives fregwb to choose integer or float register writeback.
- Handles FEQ/FLT/FLE internally.
- Dispatches FADD/FSUB/FMUL/FDIV/FSQRT/FCVT to an external pipelined float datapath and tracks each op's fixed latency with a down-counter.

---
 rtl/fpu_dispatch.sv | 199 +++++++++++++++++++
 tb/tb_fpu_dispatch.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/fpu_dispatch.sv
// Float op dispatcher: compares in-house, arithmetic issued to an external fixed-latency datapath.
// Optional FPU_ILLEGAL_TRAP_EN adds an fpu_illegal pulse alongside fpu_valid for undecodable ops.
module fpu_dispatch #(
    parameter int unsigned LAT_ADD  = 1,
    parameter int unsigned LAT_MUL  = 2,
    parameter int unsigned LAT_DIV  = 10,
    parameter int unsigned LAT_SQRT = 10,
    parameter int unsigned LAT_CVT  = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        fpu_go,
    input  logic [6:0]  funct7,
    input  logic [2:0]  funct3,
    input  logic [31:0] fsrc1,
    input  logic [31:0] fsrc2,
    input  logic [31:0] isrc1,
    output logic        fpu_valid,
    output logic        fregwb,
    output logic [31:0] fpu_result,
    output logic        unit_start,
    output logic [2:0]  unit_op,
    output logic [31:0] unit_a,
    output logic [31:0] unit_b,
    input  logic [31:0] unit_result
`ifdef FPU_ILLEGAL_TRAP_EN
    ,
    output logic        fpu_illegal
`endif
);

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] OP_ADD     = 3'd0;
    localparam logic [2:0] OP_SUB     = 3'd1;
    localparam logic [2:0] OP_MUL     = 3'd2;
    localparam logic [2:0] OP_DIV     = 3'd3;
    localparam logic [2:0] OP_SQRT    = 3'd4;
    localparam logic [2:0] OP_CVT_W_S = 3'd5;
    localparam logic [2:0] OP_CVT_S_W = 3'd6;

    localparam logic [6:0] F7_CMP = 7'b1010000;

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CMP, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [6:0]       f7_q;
    logic [2:0]       f3_q;
    logic [31:0]      a_q;
    logic [31:0]      b_q;
    logic [3:0]       dec_in;
    logic             cmp_legal;
    logic             cmp_true;

    // {is_datapath_op, unit_op}; compare and illegal encodings report 0 in the top bit
    function automatic logic [3:0] decode_f7(input logic [6:0] f7);
        logic [3:0] d;
        case (f7)
            7'b0000000: d = {1'b1, OP_ADD};
            7'b0000100: d = {1'b1, OP_SUB};
            7'b0001000: d = {1'b1, OP_MUL};
            7'b0001100: d = {1'b1, OP_DIV};
            7'b0101100: d = {1'b1, OP_SQRT};
            7'b1100000: d = {1'b1, OP_CVT_W_S};
            7'b1101000: d = {1'b1, OP_CVT_S_W};
            default:    d = 4'd0;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] lat_raw(input logic [2:0] op);
        logic [31:0] l;
        case (op)
            OP_ADD, OP_SUB:         l = 32'(LAT_ADD);
            OP_MUL:                 l = 32'(LAT_MUL);
            OP_DIV:                 l = 32'(LAT_DIV);
            OP_SQRT:                l = 32'(LAT_SQRT);
            OP_CVT_W_S, OP_CVT_S_W: l = 32'(LAT_CVT);
            default:                l = 32'd1;
        endcase
        return l;
    endfunction

    // A zero latency would never satisfy the count==1 capture, so it is clamped to one cycle
    function automatic logic [CNT_W-1:0] lat_of(input logic [2:0] op);
        logic [31:0] l;
        l = lat_raw(op);
        return (l == 32'd0) ? CNT_W'(1) : CNT_W'(l);
    endfunction

    function automatic logic cmp_eval(input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
        logic nan_a, nan_b, both_zero, eq, lt, r;
        nan_a     = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        nan_b     = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        both_zero = (a[30:0] == 31'd0) && (b[30:0] == 31'd0);
        eq        = (a == b) || both_zero;
        if (a[31] != b[31])
            lt = a[31] && !both_zero;
        else if (!a[31])
            lt = a[30:0] < b[30:0];
        else
            lt = a[30:0] > b[30:0];
        case (f3)
            3'b010:  r = eq;
            3'b001:  r = lt;
            3'b000:  r = lt || eq;
            default: r = 1'b0;
        endcase
        return r && !nan_a && !nan_b;
    endfunction

    always_comb begin
        dec_in    = decode_f7(funct7);
        cmp_legal = (f7_q == F7_CMP) && (f3_q <= 3'b010);
        cmp_true  = cmp_eval(f3_q, a_q, b_q);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            f7_q       <= '0;
            f3_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            fpu_valid  <= 1'b0;
            fregwb     <= 1'b0;
            fpu_result <= '0;
            unit_start <= 1'b0;
            unit_op    <= '0;
            unit_a     <= '0;
            unit_b     <= '0;
`ifdef FPU_ILLEGAL_TRAP_EN
            fpu_illegal <= 1'b0;
`endif
        end else begin
            unit_start <= 1'b0;
            fpu_valid  <= 1'b0;
`ifdef FPU_ILLEGAL_TRAP_EN
            fpu_illegal <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (fpu_go) begin
                        f7_q <= funct7;
                        f3_q <= funct3;
                        a_q  <= fsrc1;
                        b_q  <= fsrc2;
                        if (dec_in[3]) begin
                            state      <= ISSUE;
                            unit_start <= 1'b1;
                            unit_op    <= dec_in[2:0];
                            unit_a     <= (dec_in[2:0] == OP_CVT_S_W) ? isrc1 : fsrc1;
                            unit_b     <= fsrc2;
                        end else begin
                            state <= CMP;
                        end
                    end
                end
                ISSUE: begin
                    cnt   <= lat_of(unit_op);
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt == CNT_W'(1)) begin
                        fpu_result <= unit_result;
                        fregwb     <= (unit_op == OP_CVT_W_S);
                        fpu_valid  <= 1'b1;
                        cnt        <= '0;
                        state      <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                CMP: begin
                    fpu_result <= {31'd0, cmp_legal && cmp_true};
                    fregwb     <= cmp_legal;
                    fpu_valid  <= 1'b1;
`ifdef FPU_ILLEGAL_TRAP_EN
                    fpu_illegal <= !cmp_legal;
`endif
                    state      <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Flags a zero latency parameter at the moment it would be used
    always @(posedge clk) begin
        if (rstn && state == ISSUE)
            assert (lat_raw(unit_op) != 32'd0)
            else $error("fpu_dispatch: zero latency configured for unit_op %0d", unit_op);
    end

endmodule

// File: tb/tb_fpu_dispatch.sv
// Directed bench for fpu_dispatch with a fixed-latency datapath stub.
module tb_fpu_dispatch;

    logic        clk = 1'b0;
    logic        rstn;
    logic        fpu_go;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] fsrc1, fsrc2, isrc1;
    logic        fpu_valid, fregwb, unit_start;
    logic [31:0] fpu_result, unit_a, unit_b, unit_result;
    logic [2:0]  unit_op;
    logic        fpu_illegal;

    int n_checks = 0;
    int n_fail   = 0;
    int n_starts = 0;
    int age      = 0;
    int stub_lat = 1;
    logic [31:0] stub_val = 32'h0;

    always #5 clk = ~clk;

    fpu_dispatch dut (
        .clk(clk), .rstn(rstn), .fpu_go(fpu_go), .funct7(funct7), .funct3(funct3),
        .fsrc1(fsrc1), .fsrc2(fsrc2), .isrc1(isrc1), .fpu_valid(fpu_valid),
        .fregwb(fregwb), .fpu_result(fpu_result), .unit_start(unit_start),
        .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b), .unit_result(unit_result)
`ifdef FPU_ILLEGAL_TRAP_EN
        , .fpu_illegal(fpu_illegal)
`endif
    );

`ifndef FPU_ILLEGAL_TRAP_EN
    assign fpu_illegal = 1'b0;
`endif

    // Datapath stub: the real result appears only exactly stub_lat cycles after unit_start
    always @(posedge clk) begin
        if (unit_start) begin
            age <= 1;
            n_starts <= n_starts + 1;
        end else if (age > 0) begin
            age <= age + 1;
        end
    end
    assign unit_result = (age == stub_lat) ? stub_val : 32'hDEADBEEF;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Returns at the negedge of cycle T+1, where T is the cycle fpu_go was high
    task automatic issue(input logic [6:0] f7, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] i);
        @(negedge clk);
        funct7 = f7; funct3 = f3; fsrc1 = a; fsrc2 = b; isrc1 = i;
        fpu_go = 1'b1;
        @(negedge clk);
        fpu_go = 1'b0;
    endtask

    // Cycle offset from T at which fpu_valid is seen, or -1 on timeout
    task automatic wait_valid(input int budget, output int lat);
        lat = 1;
        while (!fpu_valid && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        if (!fpu_valid) lat = -1;
    endtask

    task automatic run_unit(input string tag, input logic [6:0] f7, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] i, input int lat_exp,
                            input logic [31:0] res, input logic [2:0] op_exp,
                            input logic [31:0] a_exp, input logic wb_exp);
        int lat;
        stub_lat = lat_exp - 2;
        stub_val = res;
        issue(f7, 3'b000, a, b, i);
        check({tag, "_start"}, 32'(unit_start), 32'd1);
        check({tag, "_op"}, 32'(unit_op), 32'(op_exp));
        check({tag, "_a"}, unit_a, a_exp);
        wait_valid(40, lat);
        check({tag, "_lat"}, 32'(lat), 32'(lat_exp));
        check({tag, "_result"}, fpu_result, res);
        check({tag, "_fregwb"}, 32'(fregwb), 32'(wb_exp));
        @(negedge clk);
        check({tag, "_pulse"}, 32'(fpu_valid), 32'd0);
    endtask

    task automatic run_cmp(input string tag, input logic [6:0] f7, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] res, input logic wb_exp, input logic ill_exp);
        int lat;
        issue(f7, f3, a, b, 32'h0);
        wait_valid(10, lat);
        check({tag, "_lat"}, 32'(lat), 32'd2);
        check({tag, "_result"}, fpu_result, res);
        check({tag, "_fregwb"}, 32'(fregwb), 32'(wb_exp));
`ifdef FPU_ILLEGAL_TRAP_EN
        check({tag, "_illegal"}, 32'(fpu_illegal), 32'(ill_exp));
`else
        check({tag, "_illegal"}, 32'(fpu_illegal | ill_exp & 1'b0), 32'd0);
`endif
        @(negedge clk);
    endtask

    initial begin
        int lat, starts0, extra_valid;
        rstn = 1'b0; fpu_go = 1'b0; funct7 = '0; funct3 = '0;
        fsrc1 = '0; fsrc2 = '0; isrc1 = '0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(fpu_valid), 32'd0);
        check("rst_result", fpu_result, 32'd0);
        check("rst_start", 32'(unit_start), 32'd0);
        check("rst_unit_a", unit_a, 32'd0);
        rstn = 1'b1;
        @(negedge clk);

        run_unit("fadd", 7'b0000000, 32'h3F800000, 32'h40000000, 32'h0, 3,
                 32'h40400000, 3'd0, 32'h3F800000, 1'b0);
        check("fadd_unit_b", unit_b, 32'h40000000);

        // FDIV with a second fpu_go at T+5 that must be dropped
        stub_lat = 10; stub_val = 32'h3EAAAAAB;
        starts0 = n_starts;
        issue(7'b0001100, 3'b000, 32'h3F800000, 32'h40400000, 32'h0);
        lat = -1;
        for (int k = 2; k <= 20; k++) begin
            @(negedge clk);
            fpu_go = (k == 5);
            funct7 = 7'b0000000;
            if (fpu_valid && lat < 0) begin
                lat = k;
                check("fdiv_result", fpu_result, 32'h3EAAAAAB);
            end
        end
        fpu_go = 1'b0;
        check("fdiv_lat", 32'(lat), 32'd12);
        check("fdiv_starts", 32'(n_starts - starts0), 32'd1);

        run_unit("fcvt_s_w", 7'b1101000, 32'hFFFFFFFF, 32'h0, 32'h00000005, 3,
                 32'h40A00000, 3'd6, 32'h00000005, 1'b0);
        run_unit("fcvt_w_s", 7'b1100000, 32'h40A00000, 32'h0, 32'h0, 3,
                 32'h00000005, 3'd5, 32'h40A00000, 1'b1);
        run_unit("fmul", 7'b0001000, 32'h40000000, 32'h40400000, 32'h0, 4,
                 32'h40C00000, 3'd2, 32'h40000000, 1'b0);

        run_cmp("flt_neg_pos", 7'b1010000, 3'b001, 32'hBF800000, 32'h3F800000, 32'd1, 1'b1, 1'b0);
        run_cmp("feq_zeros",   7'b1010000, 3'b010, 32'h80000000, 32'h00000000, 32'd1, 1'b1, 1'b0);
        run_cmp("fle_nan",     7'b1010000, 3'b000, 32'h7FC00000, 32'h3F800000, 32'd0, 1'b1, 1'b0);
        run_cmp("flt_two_neg", 7'b1010000, 3'b001, 32'hC0000000, 32'hBF800000, 32'd1, 1'b1, 1'b0);
        run_cmp("flt_zeros",   7'b1010000, 3'b001, 32'h80000000, 32'h00000000, 32'd0, 1'b1, 1'b0);
        run_cmp("fle_equal",   7'b1010000, 3'b000, 32'h3F800000, 32'h3F800000, 32'd1, 1'b1, 1'b0);
        run_cmp("illegal_f7",  7'b1111111, 3'b000, 32'h3F800000, 32'h3F800000, 32'd0, 1'b0, 1'b1);
        run_cmp("flt_pos_big", 7'b1010000, 3'b001, 32'h3F800000, 32'h40000000, 32'd1, 1'b1, 1'b0);
        run_cmp("illegal_f3",  7'b1010000, 3'b011, 32'h3F800000, 32'h40000000, 32'd0, 1'b0, 1'b1);

        // Reset while FMUL is waiting on the datapath
        stub_lat = 2; stub_val = 32'h41000000;
        issue(7'b0001000, 3'b000, 32'h40000000, 32'h40800000, 32'h0);
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("rstmid_valid", 32'(fpu_valid), 32'd0);
        check("rstmid_start", 32'(unit_start), 32'd0);
        check("rstmid_op", 32'(unit_op), 32'd0);
        check("rstmid_a", unit_a, 32'd0);
        check("rstmid_b", unit_b, 32'd0);
        check("rstmid_result", fpu_result, 32'd0);
        check("rstmid_fregwb", 32'(fregwb), 32'd0);
        rstn = 1'b1;
        extra_valid = 0;
        repeat (6) begin
            @(negedge clk);
            if (fpu_valid) extra_valid++;
        end
        check("rstmid_no_valid", 32'(extra_valid), 32'd0);
        run_unit("fadd_after_rst", 7'b0000000, 32'h3F800000, 32'h3F800000, 32'h0, 3,
                 32'h40000000, 3'd0, 32'h3F800000, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the run ever stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
